seq_mul_add: RTL and testbench
==============================

SEQ_MUL_ADD -- requirements
Module: seq_mul_add

Purpose: rebuilds a dividend from divider outputs, Result = Quotient*Divisor + Remainder, using a sequential shift-add datapath.

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits.
REQ-002 SHALL have port Clock  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port Resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Go  input  1  start request, active-high, sampled only in IDLE.
REQ-005 SHALL have port Quotient  input  WIDTH  multiplier operand, unsigned.
REQ-006 SHALL have port Divisor  input  WIDTH  multiplicand operand, unsigned.
REQ-007 SHALL have port Remainder  input  WIDTH  addend, unsigned.
REQ-008 SHALL have port Result  output  2*WIDTH  registered reconstructed dividend.
REQ-009 SHALL have port Busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port Invalid  output  1  registered flag, high when the captured Remainder >= Divisor.

Function
REQ-012 SHALL implement three states, IDLE, RUN and DONE, with all outputs registered.
REQ-013 IDLE: when Go=1 at a rising edge, SHALL capture Quotient, Divisor and Remainder, clear the step counter and go to RUN; when Go=0, SHALL stay in IDLE.
REQ-014 Capture: accumulator = Remainder zero-extended to 2*WIDTH; multiplicand = Divisor zero-extended to 2*WIDTH; multiplier = Quotient.
REQ-015 Operand inputs SHALL be ignored after capture; changing them mid-operation SHALL NOT affect Result.
REQ-016 RUN, each edge: if the multiplier LSB is 1, add the multiplicand to the accumulator; shift the multiplicand left by 1; shift the multiplier right by 1; increment the counter.
REQ-017 RUN SHALL last exactly WIDTH edges; on the WIDTH-th RUN edge the block SHALL load Result from the final accumulator, load Invalid, and enter DONE.
REQ-018 Latency: Done SHALL be high during the cycle that begins WIDTH+1 rising edges after the edge that sampled Go.
REQ-019 DONE SHALL last one cycle with Done=1 and SHALL then return to IDLE; in DONE, Go SHALL be ignored.
REQ-020 Go asserted while Busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-021 With Go held high continuously, a new operation SHALL start on the first IDLE edge, giving one result every WIDTH+2 cycles.
REQ-022 Result and Invalid SHALL hold their values until the next completion.
REQ-023 Arithmetic SHALL be unsigned; the maximum value, (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W, fits in 2*WIDTH bits, so no overflow output is provided.
REQ-024 Invalid SHALL be 1 when Divisor=0 (any Remainder), or when Remainder >= Divisor; Result SHALL still be computed normally in those cases.
REQ-025 Busy SHALL be 1 in RUN and DONE and 0 in IDLE.

Reset
REQ-026 Resetn=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, Result=0, Done=0, Busy=0, Invalid=0, and clear the accumulator, the operand registers and the counter.
REQ-027 A reset during RUN or DONE SHALL abort the operation, with no Done pulse; after Resetn rises, the first edge with Go=1 SHALL start a fresh operation.
REQ-028 Go sampled on the first edge after reset release SHALL be honored.

Verification (WIDTH=4)
REQ-029 Basic: Q=3, D=5, R=2, one-cycle Go -> Done exactly 5 edges after the Go edge, Result=17, Invalid=0, Busy high for 5 cycles.
REQ-030 Maximum: Q=15, D=15, R=14 -> Result=239, Invalid=0; also Q=0, D=9, R=4 -> Result=4.
REQ-031 Invalid: Q=2, D=0, R=3 -> Result=3, Invalid=1; Q=1, D=4, R=4 -> Result=8, Invalid=1.
REQ-032 Go during Busy, operands changed: start Q=6, D=7, R=1, pulse Go at the 2nd RUN cycle, change Q to 9 -> single Done, Result=43, no second operation.
REQ-033 Reset mid-run: assert Resetn=0 at the 2nd RUN cycle -> outputs 0 immediately, no Done; a restart with Q=2, D=3, R=0 -> Result=6.
REQ-034 Back-to-back: Go held high with Q=1, D=1, R=0 -> Done pulses spaced 6 cycles apart, each with Result=1.

Source files
------------

// File: rtl/seq_mul_add.sv
// Sequential shift-add reconstruction of a dividend: Result = Quotient*Divisor + Remainder.
// One operation takes WIDTH RUN cycles plus one DONE cycle. Done is asserted in the cycle after DONE.
module seq_mul_add #(
    parameter int WIDTH = 4
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 Go,
    input  logic [WIDTH-1:0]     Quotient,
    input  logic [WIDTH-1:0]     Divisor,
    input  logic [WIDTH-1:0]     Remainder,
    output logic [2*WIDTH-1:0]   Result,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Invalid
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [2*WIDTH-1:0]   acc_reg, acc_next;
    logic [2*WIDTH-1:0]   mcand_reg, mcand_next;
    logic [WIDTH-1:0]     mplier_reg, mplier_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic                 inv_pend_reg, inv_pend_next;
    logic [2*WIDTH-1:0]   result_reg, result_next;
    logic                 invalid_reg, invalid_next;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;
    logic [2*WIDTH-1:0]   acc_step;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            cnt_reg      <= '0;
            inv_pend_reg <= 1'b0;
            result_reg   <= '0;
            invalid_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            mcand_reg    <= mcand_next;
            mplier_reg   <= mplier_next;
            cnt_reg      <= cnt_next;
            inv_pend_reg <= inv_pend_next;
            result_reg   <= result_next;
            invalid_reg  <= invalid_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        mcand_next    = mcand_reg;
        mplier_next   = mplier_reg;
        cnt_next      = cnt_reg;
        inv_pend_next = inv_pend_reg;
        result_next   = result_reg;
        invalid_next  = invalid_reg;
        acc_step      = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

        case (state_reg)
            IDLE: begin
                if (Go) begin
                    acc_next      = {{WIDTH{1'b0}}, Remainder};
                    mcand_next    = {{WIDTH{1'b0}}, Divisor};
                    mplier_next   = Quotient;
                    cnt_next      = '0;
                    // Divisor == 0 is covered too, since any Remainder >= 0.
                    inv_pend_next = (Remainder >= Divisor);
                    state_next    = RUN;
                end
            end
            RUN: begin
                acc_next    = acc_step;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + 1'b1;
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    result_next  = acc_step;
                    invalid_next = inv_pend_reg;
                    state_next   = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
        done_next = (state_reg == DONE);
    end

    assign Result  = result_reg;
    assign Invalid = invalid_reg;
    assign Busy    = busy_reg;
    assign Done    = done_reg;

endmodule

// File: tb/tb_seq_mul_add.sv
// Randomized and directed checks of seq_mul_add (WIDTH=4) against an arithmetic reference model.
module tb_seq_mul_add;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           go;
    logic [W-1:0]   quo, dvs, rem;
    logic [2*W-1:0] result;
    logic           busy, done, invalid;

    int n_checks = 0;
    int n_fail   = 0;

    seq_mul_add #(.WIDTH(W)) dut (
        .Clock     (clk),
        .Resetn    (rst_n),
        .Go        (go),
        .Quotient  (quo),
        .Divisor   (dvs),
        .Remainder (rem),
        .Result    (result),
        .Busy      (busy),
        .Done      (done),
        .Invalid   (invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_result(input int q, input int d, input int r);
        return q * d + r;
    endfunction

    function automatic int model_invalid(input int d, input int r);
        return (d == 0 || r >= d) ? 1 : 0;
    endfunction

    // Entered and left at a negedge. mode 0: quiet, 1: Go pulse + Q=9 at 2nd RUN cycle,
    // 2: random Go/operand noise while busy.
    task automatic do_op(input int q, input int d, input int r, input int mode);
        int cycles;
        int busy_cnt;
        int exp_res, exp_inv;
        exp_res = model_result(q, d, r);
        exp_inv = model_invalid(d, r);
        go  = 1'b1;
        quo = W'(q);
        dvs = W'(d);
        rem = W'(r);
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        busy_cnt = busy ? 1 : 0;
        cycles = 0;
        while (!done && cycles < 20) begin
            if (mode == 1 && cycles == 1) begin
                go  = 1'b1;
                quo = W'(9);
            end else if (mode == 1 && cycles == 2) begin
                go = 1'b0;
            end else if (mode == 2 && cycles < W) begin
                go  = 1'($urandom_range(0, 1));
                quo = W'($urandom);
                dvs = W'($urandom);
                rem = W'($urandom);
            end else begin
                go = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (busy) busy_cnt++;
        end
        go = 1'b0;
        $display("op q=%0d d=%0d r=%0d mode=%0d -> result=%0d invalid=%0d after %0d edges",
                 q, d, r, mode, result, invalid, cycles);
        check("done_latency", cycles, W + 1);
        check("result", result, exp_res);
        check("invalid", invalid, exp_inv);
        check("busy_cycles", busy_cnt, W + 1);
        check("busy_at_done", busy, 0);
        @(posedge clk);
        @(negedge clk);
        check("done_single", done, 0);
        check("no_requeue", busy, 0);
        check("result_hold", result, exp_res);
    endtask

    initial begin
        int last_done, n_done;
        rst_n = 1'b0;
        go    = 1'b0;
        quo   = '0;
        dvs   = '0;
        rem   = '0;
        #1;
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_invalid", invalid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Go on the first edge after reset release.
        do_op(3, 5, 2, 0);
        do_op(15, 15, 14, 0);
        do_op(0, 9, 4, 0);
        do_op(2, 0, 3, 0);
        do_op(1, 4, 4, 0);
        do_op(6, 7, 1, 1);

        // Abort mid-run with an asynchronous reset.
        go = 1'b1; quo = 4'd5; dvs = 4'd5; rem = 4'd1;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        $display("reset mid-run -> result=%0d busy=%0d done=%0d invalid=%0d", result, busy, done, invalid);
        check("abort_result", result, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_invalid", invalid, 0);
        n_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        rst_n = 1'b1;
        do_op(2, 3, 0, 0);

        for (int i = 0; i < 20; i++) begin
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), 2);
        end

        // Back-to-back with Go held high.
        go = 1'b1; quo = 4'd1; dvs = 4'd1; rem = 4'd0;
        last_done = -1;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                $display("b2b done at cycle %0d result=%0d", c, result);
                check("b2b_result", result, 1);
                if (last_done >= 0) check("b2b_spacing", c - last_done, W + 2);
                last_done = c;
                n_done++;
            end
        end
        check("b2b_count_min", (n_done >= 5) ? 1 : 0, 1);
        go = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
